// File: rtl/write_operation_pkg.sv
// Shared constants for the register-file write half: sizes, reset default,
// and the saturating rewrite-counter limits.
package write_operation_pkg;
  localparam int                DATA_WIDTH_DEF  = 32;
  localparam int                REG_COUNT       = 8;
  localparam int                ADDR_WIDTH      = 3;
  localparam logic [31:0]       RESET_VALUE_DEF = 32'h0000_0000;
  localparam int                CNT_WIDTH       = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_SAT      = 8'hFF;
endpackage

// File: rtl/write_operation_register_en.sv
// Single register with a synchronous active-low reset and a load enable.
module register_en #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DATA_WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)   q_q <= RESET_VALUE;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/write_operation.sv
// Write half of the 8-entry register file: one-hot write decode, registered
// ack, and a saturating same-address rewrite counter.
// Build option: define ZERO_REG_EN to hardwire register 0 to zero.
module write_operation
  import write_operation_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(RESET_VALUE_DEF)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  output logic [DATA_WIDTH-1:0] from_reg0,
  output logic [DATA_WIDTH-1:0] from_reg1,
  output logic [DATA_WIDTH-1:0] from_reg2,
  output logic [DATA_WIDTH-1:0] from_reg3,
  output logic [DATA_WIDTH-1:0] from_reg4,
  output logic [DATA_WIDTH-1:0] from_reg5,
  output logic [DATA_WIDTH-1:0] from_reg6,
  output logic [DATA_WIDTH-1:0] from_reg7,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] wr_ack_addr,
  output logic [CNT_WIDTH-1:0]  rewrite_cnt
);
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [REG_COUNT-1:0]                 en;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;

  assign en = we ? (REG_COUNT'(1) << wAddr) : '0;

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    if (ZERO_REG && i == 0) begin : g_zero
      // Write still decodes to en[0]; the data is simply never stored.
      assign regs[i] = '0;
    end else begin : g_ff
      register_en #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE(RESET_VALUE)) u_reg (
        .clk_i (clk),
        .rst_ni(reset_n),
        .en_i  (en[i]),
        .d_i   (wData),
        .q_o   (regs[i])
      );
    end
  end

  assign from_reg0 = regs[0];
  assign from_reg1 = regs[1];
  assign from_reg2 = regs[2];
  assign from_reg3 = regs[3];
  assign from_reg4 = regs[4];
  assign from_reg5 = regs[5];
  assign from_reg6 = regs[6];
  assign from_reg7 = regs[7];

  logic                  ack_q, ack_d;
  logic [ADDR_WIDTH-1:0] ack_addr_q, ack_addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  last_valid_q, last_valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    ack_d        = we;
    ack_addr_d   = ack_addr_q;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
    cnt_d        = cnt_q;
    if (we) begin
      ack_addr_d   = wAddr;
      last_addr_d  = wAddr;
      last_valid_d = 1'b1;
      if (last_valid_q && wAddr == last_addr_q && cnt_q != CNT_SAT)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q        <= 1'b0;
      ack_addr_q   <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ack_q        <= ack_d;
      ack_addr_q   <= ack_addr_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wr_ack      = ack_q;
  assign wr_ack_addr = ack_addr_q;
  assign rewrite_cnt = cnt_q;
endmodule

// File: tb/tb_write_operation.sv
// Directed bench for write_operation: reset, fill, enable gating, rewrite
// saturation, mid-stream reset and the register-0 behaviour.
module tb_write_operation;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [2:0]  wAddr;
  logic [31:0] wData;
  logic [31:0] from_reg0, from_reg1, from_reg2, from_reg3;
  logic [31:0] from_reg4, from_reg5, from_reg6, from_reg7;
  logic        wr_ack;
  logic [2:0]  wr_ack_addr;
  logic [7:0]  rewrite_cnt;

  int checks = 0;
  int errors = 0;

  write_operation dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
    .from_reg0(from_reg0), .from_reg1(from_reg1), .from_reg2(from_reg2),
    .from_reg3(from_reg3), .from_reg4(from_reg4), .from_reg5(from_reg5),
    .from_reg6(from_reg6), .from_reg7(from_reg7),
    .wr_ack(wr_ack), .wr_ack_addr(wr_ack_addr), .rewrite_cnt(rewrite_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] r [8];
  assign r[0] = from_reg0; assign r[1] = from_reg1;
  assign r[2] = from_reg2; assign r[3] = from_reg3;
  assign r[4] = from_reg4; assign r[5] = from_reg5;
  assign r[6] = from_reg6; assign r[7] = from_reg7;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs, clock once, settle past the edge.
  task automatic cyc(input logic rn, input logic w, input logic [2:0] a, input logic [31:0] d);
    reset_n = rn; we = w; wAddr = a; wData = d;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fill [8];
  logic [31:0] exp_r0;

  initial begin
    fill[0] = 32'h0000_0000; fill[1] = 32'h0000_0001;
    fill[2] = 32'h0000_0011; fill[3] = 32'h0000_0111;
    fill[4] = 32'h0000_1111; fill[5] = 32'h0001_1111;
    fill[6] = 32'h0011_1111; fill[7] = 32'h0111_1111;

    // Reset overrides a pending write.
    cyc(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_reg%0d", i), r[i], 32'h0);
    chk("rst_ack", {31'b0, wr_ack}, 32'h0);
    chk("rst_ackaddr", {29'b0, wr_ack_addr}, 32'h0);
    chk("rst_cnt", {24'b0, rewrite_cnt}, 32'h0);

    // Sequential fill, one write per cycle.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 3'(i), fill[i]);
      chk($sformatf("fill_reg%0d", i), r[i], fill[i]);
      chk($sformatf("fill_ack%0d", i), {31'b0, wr_ack}, 32'h1);
      chk($sformatf("fill_ackaddr%0d", i), {29'b0, wr_ack_addr}, 32'(i));
      chk($sformatf("fill_cnt%0d", i), {24'b0, rewrite_cnt}, 32'h0);
    end

    // we=0: nothing changes, ack drops.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 3'd5, 32'hFFFF_FFFF);
      chk("gate_reg5", r[5], 32'h0001_1111);
      chk("gate_ack", {31'b0, wr_ack}, 32'h0);
      chk("gate_ackaddr", {29'b0, wr_ack_addr}, 32'd7);
    end
    for (int i = 1; i < 8; i++) chk($sformatf("hold_reg%0d", i), r[i], fill[i]);

    // Rewrites to address 2: first follows addr 7, so it is not a rewrite.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 3'd2, 32'hA000_0000 + 32'(k));
      chk($sformatf("rw_cnt%0d", k), {24'b0, rewrite_cnt}, 32'(k));
    end
    chk("rw_reg2", r[2], 32'hA000_0003);
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 1'b1, 3'd2, 32'hB000_0000 + 32'(k));
      if (k == 251) chk("rw_cnt_at_ff", {24'b0, rewrite_cnt}, 32'hFF);
    end
    chk("rw_cnt_sat", {24'b0, rewrite_cnt}, 32'hFF);
    chk("rw_reg2_last", r[2], 32'hB000_012B);

    // Mid-stream reset with a write pending.
    cyc(1'b1, 1'b1, 3'd6, 32'h6666_6666);
    chk("mid_reg6", r[6], 32'h6666_6666);
    cyc(1'b0, 1'b1, 3'd6, 32'h7777_7777);
    for (int i = 0; i < 8; i++) chk($sformatf("mid_rst_reg%0d", i), r[i], 32'h0);
    chk("mid_rst_ack", {31'b0, wr_ack}, 32'h0);
    chk("mid_rst_cnt", {24'b0, rewrite_cnt}, 32'h0);
    cyc(1'b1, 1'b1, 3'd6, 32'h5555_5555);
    chk("post_cnt", {24'b0, rewrite_cnt}, 32'h0);
    chk("post_ack", {31'b0, wr_ack}, 32'h1);
    chk("post_ackaddr", {29'b0, wr_ack_addr}, 32'd6);
    chk("post_reg6", r[6], 32'h5555_5555);

    // Register 0 write; tracking still sees it.
`ifdef ZERO_REG_EN
    exp_r0 = 32'h0;
`else
    exp_r0 = 32'h1234_5678;
`endif
    cyc(1'b1, 1'b1, 3'd0, 32'h1234_5678);
    chk("r0_val", r[0], exp_r0);
    chk("r0_ack", {31'b0, wr_ack}, 32'h1);
    chk("r0_ackaddr", {29'b0, wr_ack_addr}, 32'h0);
    cyc(1'b1, 1'b1, 3'd0, 32'h1234_5678);
    chk("r0_cnt", {24'b0, rewrite_cnt}, 32'h1);
    cyc(1'b1, 1'b0, 3'd0, 32'h0);
    chk("end_ack", {31'b0, wr_ack}, 32'h0);
    chk("end_reg6", r[6], 32'h5555_5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
